ps2_mouse_tracker: RTL and testbench
====================================

// Module: ps2_mouse_tracker
// PURPOSE
//  Consumes the byte stream from PS2_Controller (INITIALIZE_MOUSE=1) and decodes standard 3-byte PS/2 mouse packets.
//  Maintains a clamped cursor position for a parametrised screen, and reports three buttons.
//  Adds an inter-byte timeout resynchroniser, selectable Y direction and a per-packet valid strobe.
//  Sits between PS2_Controller and the game/VGA logic as the single source of cursor state.
// PARAMETERS
//  SCREEN_W     640        horizontal extent; x range 0..SCREEN_W-1
//  SCREEN_H     480        vertical extent; y range 0..SCREEN_H-1
//  X_W          10         width of mouse_x; must satisfy 2**X_W >= SCREEN_W
//  Y_W          9          width of mouse_y; must satisfy 2**Y_W >= SCREEN_H
//  INIT_X       SCREEN_W/2 x value after reset
//  INIT_Y       SCREEN_H/2 y value after reset
//  Y_UP_NEG     1          1: positive PS/2 dy decreases mouse_y (screen-up); 0: increases it
//  TIMEOUT_CYC  1000000    idle clocks mid-packet before the FSM drops the partial packet (20 ms @ 50 MHz)
// PORTS
//  clock          in   1    system clock (CLOCK_50)
//  reset          in   1    synchronous, active-high reset
//  ps2_data       in   8    received byte from PS2_Controller
//  ps2_data_en    in   1    one-cycle strobe; ps2_data is valid this cycle
//  mouse_x        out  X_W  cursor x, registered
//  mouse_y        out  Y_W  cursor y, registered
//  left_button    out  1    byte0[0] of the last complete packet, registered
//  right_button   out  1    byte0[1] of the last complete packet, registered
//  middle_button  out  1    byte0[2] of the last complete packet, registered
//  packet_valid   out  1    one-cycle pulse when the outputs above take a new packet
//  packet_drop    out  1    one-cycle pulse when a byte or partial packet is discarded
//  left_click     out  1    [MOUSE_CLICK_EDGE_EN only] one-cycle pulse on a left 0->1 transition
//  right_click    out  1    [MOUSE_CLICK_EDGE_EN only] one-cycle pulse on a right 0->1 transition
// BEHAVIOUR
//  Reset values: mouse_x=INIT_X, mouse_y=INIT_Y; all buttons, pulses and counters 0; FSM in S_B0.
//  A reset asserted mid-packet discards the partial packet.
//  FSM S_B0:
//   - data_en with data[3]=1: latch byte0, go to S_B1.
//   - data_en with data[3]=0: discard the byte, pulse packet_drop, stay in S_B0.
//  FSM S_B1: data_en latches dx, go to S_B2.
//  FSM S_B2: data_en is the third byte; commit on this edge, go to S_B0.
//  Commit latency: outputs and packet_valid are updated on the clock edge that samples the 3rd byte's data_en.
//   They are visible the following cycle. The 3rd byte is used directly, not from a register.
//  Delta arithmetic:
//   - Each delta is a 9-bit signed value {sign bit from byte0, byte}.
//   - The overflow bit (byte0[6] for x, byte0[7] for y) saturates the delta to +255 or -255.
//   - Sum computed in signed (X_W+2) / (Y_W+2) bits, then clamped to [0, SCREEN-1].
//   - Y_UP_NEG=1 negates dy before the add.
//  Timeout:
//   - idle_cnt clears on every data_en and counts only in S_B1/S_B2.
//   - When idle_cnt reaches TIMEOUT_CYC-1 with no data_en: go to S_B0, pulse packet_drop, leave outputs unchanged.
//   - If data_en and expiry fall in the same cycle, the byte wins: it is accepted and there is no drop.
//  packet_valid and packet_drop are never asserted in the same cycle.
//  Buttons update only on commit; a dropped packet does not change any output except packet_drop.
// CONFIGURATION
//  MOUSE_CLICK_EDGE_EN defined:
//   - left_click and right_click ports exist.
//   - Each is high in the same cycle as packet_valid when its button goes from 0 in the previous committed packet to 1 in the new one.
//  MOUSE_CLICK_EDGE_EN undefined: those ports and their logic are absent; everything else is identical.
// STRUCTURE
//  mouse_pkg holds:
//   - state encoding S_B0/S_B1/S_B2;
//   - byte0 bit indices (BTN_L=0, BTN_R=1, BTN_M=2, SYNC=3, XS=4, YS=5, XO=6, YO=7);
//   - DELTA_SAT=255.
//  Sub-module mouse_axis_clamp (params AXIS_MAX, W): combinational; inputs cur, byte, sign, ovf, neg; output clamped next.
//   Instantiated once for x and once for y.
// TESTING
//  1. Reset, then bytes 08,0A,05 with Y_UP_NEG=1 -> x=330, y=235, packet_valid for 1 cycle, buttons 0.
//  2. From 330,235: bytes 18,F6,00 (dx=-10) -> x=320. Then bytes 58,00,00 (x overflow, negative) -> x=65.
//     Then a further 58,00,00 -> x=0, clamped.
//  3. Bytes 28,00,F0 (dy=-16, i.e. down) from y=470 -> y=479, clamped.
//     Then 09,00,00 -> left_button=1; also left_click=1 when MOUSE_CLICK_EDGE_EN is defined.
//  4. Byte 00 in S_B0 -> packet_drop pulse, no state change. Then 08,05,05 -> normal commit.
//  5. Byte 08, then no data_en for TIMEOUT_CYC cycles -> packet_drop, outputs unchanged.
//     Next 08,01,00 -> commits x+1.
//     Repeat with data_en landing exactly in the expiry cycle -> byte accepted, no drop.
//  6. Assert reset between byte 1 and byte 2 -> x=INIT_X, y=INIT_Y, no packet_valid.
//     Then 08,01,00 -> x=INIT_X+1.

Source files
------------

// File: rtl/mouse_pkg.sv
// ---------------------------------------------------------------------------
// mouse_pkg
// Shared definitions for the PS/2 mouse tracker:
//   - packet FSM state encoding (S_B0 / S_B1 / S_B2)
//   - bit positions inside the first packet byte (buttons, sync, signs, overflows)
//   - DELTA_SAT, the magnitude a delta saturates to when its overflow bit is set
//   - hdr_t, the subset of byte 0 that must be kept until the packet commits
// ---------------------------------------------------------------------------
package mouse_pkg;

    typedef enum logic [1:0] {
        S_B0 = 2'd0,   // waiting for the header byte
        S_B1 = 2'd1,   // waiting for dx
        S_B2 = 2'd2    // waiting for dy; commit on arrival
    } state_t;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XS    = 4;
    localparam int YS    = 5;
    localparam int XO    = 6;
    localparam int YO    = 7;

    localparam int DELTA_SAT = 255;

    // Header fields retained between byte 0 and the commit. The sync bit is
    // only needed at the moment byte 0 arrives, so it is not stored.
    typedef struct packed {
        logic       yo;
        logic       xo;
        logic       ys;
        logic       xs;
        logic [2:0] btn;   // {middle, right, left}
    } hdr_t;

endpackage

// File: rtl/ps2_mouse_tracker_if.sv
// ---------------------------------------------------------------------------
// ps2_mouse_tracker_if
// Bundles the byte stream from PS2_Controller and the decoded cursor state.
//   master : byte source side (drives ps2_data / ps2_data_en, observes results)
//   slave  : the tracker (consumes bytes, drives cursor/button/pulse outputs)
// Handshake: ps2_data_en is a one-cycle strobe with no back-pressure; the
// tracker accepts every byte on the edge where ps2_data_en is high.
// Signals:
//   ps2_data[7:0], ps2_data_en            byte stream in
//   mouse_x[X_W-1:0], mouse_y[Y_W-1:0]    clamped cursor
//   left/right/middle_button              buttons of the last committed packet
//   packet_valid, packet_drop             one-cycle event pulses
//   left_click, right_click               rising-edge pulses (MOUSE_CLICK_EDGE_EN)
//   dbg_state                             current packet FSM state
// Optional macro: MOUSE_CLICK_EDGE_EN
// ---------------------------------------------------------------------------
interface ps2_mouse_tracker_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic [7:0]          ps2_data;
    logic                ps2_data_en;
    logic [X_W-1:0]      mouse_x;
    logic [Y_W-1:0]      mouse_y;
    logic                left_button;
    logic                right_button;
    logic                middle_button;
    logic                packet_valid;
    logic                packet_drop;
`ifdef MOUSE_CLICK_EDGE_EN
    logic                left_click;
    logic                right_click;
`endif
    mouse_pkg::state_t   dbg_state;

    modport master (
`ifdef MOUSE_CLICK_EDGE_EN
        input  left_click, right_click,
`endif
        output ps2_data, ps2_data_en,
        input  mouse_x, mouse_y, left_button, right_button, middle_button,
        input  packet_valid, packet_drop, dbg_state
    );

    modport slave (
`ifdef MOUSE_CLICK_EDGE_EN
        output left_click, right_click,
`endif
        input  ps2_data, ps2_data_en,
        output mouse_x, mouse_y, left_button, right_button, middle_button,
        output packet_valid, packet_drop, dbg_state
    );

endinterface

// File: rtl/mouse_axis_clamp.sv
// ---------------------------------------------------------------------------
// mouse_axis_clamp
// Combinational next-position for one axis: builds the 9-bit signed delta from
// the sign bit and data byte, saturates it to +/-DELTA_SAT when the overflow
// bit is set, optionally negates it, adds it to the current position in W+2
// signed bits and clamps the result to [0, AXIS_MAX].
// Ports:
//   i_cur  [W-1:0]  current position
//   i_byte [7:0]    delta magnitude byte
//   i_sign          delta sign bit (from byte 0)
//   i_ovf           delta overflow bit (from byte 0)
//   i_neg           negate the delta before the add
//   o_next [W-1:0]  clamped new position
// ---------------------------------------------------------------------------
module mouse_axis_clamp
    import mouse_pkg::*;
#(
    parameter int AXIS_MAX = 639,
    parameter int W        = 10
) (
    input  logic [W-1:0] i_cur,
    input  logic [7:0]   i_byte,
    input  logic         i_sign,
    input  logic         i_ovf,
    input  logic         i_neg,
    output logic [W-1:0] o_next
);

    localparam logic signed [8:0]   SAT9  = 9'(DELTA_SAT);
    localparam logic signed [W+1:0] MAX_S = (W+2)'(AXIS_MAX);

    logic signed [8:0]   w_d9;
    logic signed [W+1:0] w_delta;
    logic signed [W+1:0] w_sum;

    always_comb begin
        w_d9 = {i_sign, i_byte};
        if (i_ovf) begin
            w_d9 = i_sign ? -SAT9 : SAT9;
        end
        w_delta = {{(W-7){w_d9[8]}}, w_d9};
        if (i_neg) begin
            w_delta = -w_delta;
        end
        // Position is unsigned; two zero bits keep it positive in signed math.
        w_sum = $signed({2'b00, i_cur}) + w_delta;
        if (w_sum[W+1]) begin
            o_next = '0;
        end else if (w_sum > MAX_S) begin
            o_next = W'(AXIS_MAX);
        end else begin
            o_next = w_sum[W-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// ---------------------------------------------------------------------------
// ps2_mouse_tracker
// Decodes 3-byte PS/2 mouse packets from PS2_Controller into a clamped cursor
// position and three button levels. A partial packet is dropped after
// TIMEOUT_CYC idle clocks mid-packet; a header byte without the sync bit is
// dropped immediately. Outputs change only on commit (edge sampling byte 3).
// Ports:
//   clock   system clock
//   reset   synchronous, active-high
//   bus     ps2_mouse_tracker_if.slave (byte stream in, cursor state out)
// Optional macro: MOUSE_CLICK_EDGE_EN adds left_click/right_click pulses.
// ---------------------------------------------------------------------------
module ps2_mouse_tracker
    import mouse_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int INIT_X      = SCREEN_W / 2,
    parameter int INIT_Y      = SCREEN_H / 2,
    parameter bit Y_UP_NEG    = 1'b1,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    ps2_mouse_tracker_if.slave    bus
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           r_state;
    hdr_t             r_hdr;
    logic [7:0]       r_dx;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [2:0]       r_btn;
    logic             r_valid;
    logic             r_drop;
`ifdef MOUSE_CLICK_EDGE_EN
    logic             r_lclick;
    logic             r_rclick;
`endif

    logic [X_W-1:0]   w_next_x;
    logic [Y_W-1:0]   w_next_y;

    mouse_axis_clamp #(.AXIS_MAX(SCREEN_W - 1), .W(X_W)) u_clamp_x (
        .i_cur  (r_x),
        .i_byte (r_dx),
        .i_sign (r_hdr.xs),
        .i_ovf  (r_hdr.xo),
        .i_neg  (1'b0),
        .o_next (w_next_x)
    );

    // The dy byte is taken straight from the bus so the commit happens on the
    // same edge that samples it.
    mouse_axis_clamp #(.AXIS_MAX(SCREEN_H - 1), .W(Y_W)) u_clamp_y (
        .i_cur  (r_y),
        .i_byte (bus.ps2_data),
        .i_sign (r_hdr.ys),
        .i_ovf  (r_hdr.yo),
        .i_neg  (Y_UP_NEG),
        .o_next (w_next_y)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_B0;
            r_hdr      <= '0;
            r_dx       <= '0;
            r_idle_cnt <= '0;
            r_x        <= X_W'(INIT_X);
            r_y        <= Y_W'(INIT_Y);
            r_btn      <= '0;
            r_valid    <= 1'b0;
            r_drop     <= 1'b0;
`ifdef MOUSE_CLICK_EDGE_EN
            r_lclick   <= 1'b0;
            r_rclick   <= 1'b0;
`endif
        end else begin
            r_valid  <= 1'b0;
            r_drop   <= 1'b0;
`ifdef MOUSE_CLICK_EDGE_EN
            r_lclick <= 1'b0;
            r_rclick <= 1'b0;
`endif
            case (r_state)
                S_B0: begin
                    r_idle_cnt <= '0;
                    if (bus.ps2_data_en) begin
                        if (bus.ps2_data[SYNC]) begin
                            r_hdr   <= '{yo:  bus.ps2_data[YO], xo: bus.ps2_data[XO],
                                         ys:  bus.ps2_data[YS], xs: bus.ps2_data[XS],
                                         btn: {bus.ps2_data[BTN_M], bus.ps2_data[BTN_R],
                                               bus.ps2_data[BTN_L]}};
                            r_state <= S_B1;
                        end else begin
                            r_drop  <= 1'b1;
                        end
                    end
                end
                S_B1, S_B2: begin
                    // A byte arriving in the expiry cycle takes priority.
                    if (bus.ps2_data_en) begin
                        r_idle_cnt <= '0;
                        if (r_state == S_B1) begin
                            r_dx    <= bus.ps2_data;
                            r_state <= S_B2;
                        end else begin
                            r_x     <= w_next_x;
                            r_y     <= w_next_y;
                            r_btn   <= r_hdr.btn;
                            r_valid <= 1'b1;
`ifdef MOUSE_CLICK_EDGE_EN
                            r_lclick <= r_hdr.btn[BTN_L] & ~r_btn[BTN_L];
                            r_rclick <= r_hdr.btn[BTN_R] & ~r_btn[BTN_R];
`endif
                            r_state <= S_B0;
                        end
                    end else if (r_idle_cnt == IDLE_LAST) begin
                        r_idle_cnt <= '0;
                        r_drop     <= 1'b1;
                        r_state    <= S_B0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_B0;
                    r_idle_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.mouse_x       = r_x;
    assign bus.mouse_y       = r_y;
    assign bus.left_button   = r_btn[BTN_L];
    assign bus.right_button  = r_btn[BTN_R];
    assign bus.middle_button = r_btn[BTN_M];
    assign bus.packet_valid  = r_valid;
    assign bus.packet_drop   = r_drop;
    assign bus.dbg_state     = r_state;
`ifdef MOUSE_CLICK_EDGE_EN
    assign bus.left_click    = r_lclick;
    assign bus.right_click   = r_rclick;
`endif

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_tracker
// Directed packets with hand-computed cursor positions. Each expected commit
// is pushed to exp_q before its bytes are sent; a negedge monitor pops and
// compares whenever packet_valid is seen. Unexpected drops are caught through
// drop_q. Timeout / reset cases are checked directly at fixed cycle offsets.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_tracker;
  import mouse_pkg::*;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int TO    = 20;
  localparam int PKT_W = X_W + Y_W + 5;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ps2_mouse_tracker_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  ps2_mouse_tracker #(.TIMEOUT_CYC(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;
  int drop_seen = 0;
  logic [PKT_W-1:0] exp_q[$];
  logic drop_q[$];
  logic mdl_l = 1'b0;
  logic mdl_r = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] pack(input int x, input int y, input logic [2:0] btn,
                                            input logic lc, input logic rc);
    return {X_W'(x), Y_W'(y), btn, lc, rc};
  endfunction

  // scoreboard monitor
  always @(negedge clock) begin
    logic [PKT_W-1:0] act;
    logic [PKT_W-1:0] exp;
    logic lc;
    logic rc;
    if (!reset) begin
      check("valid_drop_excl", int'(bus.packet_valid & bus.packet_drop), 0);
      if (bus.packet_valid) begin
        valid_seen++;
`ifdef MOUSE_CLICK_EDGE_EN
        lc = bus.left_click;
        rc = bus.right_click;
`else
        lc = 1'b0;
        rc = 1'b0;
`endif
        act = pack(int'(bus.mouse_x), int'(bus.mouse_y),
                   {bus.middle_button, bus.right_button, bus.left_button}, lc, rc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid got x=%0d y=%0d exp none", bus.mouse_x, bus.mouse_y);
        end else begin
          exp = exp_q.pop_front();
          if (act != exp) begin
            failures++;
            $display("FAIL pkt%0d got x=%0d y=%0d mrl=%b clk=%b exp x=%0d y=%0d mrl=%b clk=%b",
                     valid_seen, act[PKT_W-1 -: X_W], act[Y_W+4:5], act[4:2], act[1:0],
                     exp[PKT_W-1 -: X_W], exp[Y_W+4:5], exp[4:2], exp[1:0]);
          end
        end
      end
      if (bus.packet_drop) begin
        drop_seen++;
        checks++;
        if (drop_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_drop got=1 exp=0");
        end else begin
          void'(drop_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock);
    #1;
    bus.ps2_data    = b;
    bus.ps2_data_en = 1'b1;
    @(posedge clock);
    #1;
    bus.ps2_data_en = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] b0, input int ex, input int ey);
    logic lc;
    logic rc;
`ifdef MOUSE_CLICK_EDGE_EN
    lc = b0[0] & ~mdl_l;
    rc = b0[1] & ~mdl_r;
`else
    lc = 1'b0;
    rc = 1'b0;
`endif
    mdl_l = b0[0];
    mdl_r = b0[1];
    exp_q.push_back(pack(ex, ey, b0[2:0], lc, rc));
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int ex, input int ey);
    push_exp(b0, ex, ey);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mdl_l = 1'b0;
    mdl_r = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    bus.ps2_data    = 8'h00;
    bus.ps2_data_en = 1'b0;
    do_reset();

    // reset state
    check("rst_x", int'(bus.mouse_x), 320);
    check("rst_y", int'(bus.mouse_y), 240);
    check("rst_btn", int'({bus.middle_button, bus.right_button, bus.left_button}), 0);
    check("rst_valid", int'(bus.packet_valid), 0);
    check("rst_drop", int'(bus.packet_drop), 0);
    check("rst_state", int'(bus.dbg_state), int'(S_B0));

    // basic moves and x clamping
    send_pkt(8'h08, 8'h0A, 8'h05, 330, 235);
    send_pkt(8'h18, 8'hF6, 8'h00, 320, 235);
    send_pkt(8'h58, 8'h00, 8'h00, 65, 235);
    send_pkt(8'h58, 8'h00, 8'h00, 0, 235);
    // y: dy=-235 moves down, then dy=-16 clamps at the bottom
    send_pkt(8'h28, 8'h00, 8'h15, 0, 470);
    send_pkt(8'h28, 8'h00, 8'hF0, 0, 479);
    send_pkt(8'h09, 8'h00, 8'h00, 0, 479);
    check("left_level", int'(bus.left_button), 1);

    // header without sync bit
    drop_q.push_back(1'b1);
    send_byte(8'h00);
    check("nosync_drop", int'(bus.packet_drop), 1);
    check("nosync_state", int'(bus.dbg_state), int'(S_B0));
    check("nosync_hold_l", int'(bus.left_button), 1);
    send_pkt(8'h08, 8'h05, 8'h05, 5, 474);
    send_pkt(8'h0E, 8'h00, 8'h00, 5, 474);

    // inter-byte timeout
    drop_q.push_back(1'b1);
    send_byte(8'h08);
    repeat (TO - 1) @(posedge clock);
    #1;
    check("to_early", int'(bus.packet_drop), 0);
    @(posedge clock);
    #1;
    check("to_fire", int'(bus.packet_drop), 1);
    check("to_state", int'(bus.dbg_state), int'(S_B0));
    check("to_hold_x", int'(bus.mouse_x), 5);
    check("to_hold_r", int'(bus.right_button), 1);
    send_pkt(8'h08, 8'h01, 8'h00, 6, 474);

    // byte landing in the expiry cycle is accepted
    push_exp(8'h08, 7, 474);
    send_byte(8'h08);
    repeat (TO - 1) @(posedge clock);
    #1;
    bus.ps2_data    = 8'h01;
    bus.ps2_data_en = 1'b1;
    @(posedge clock);
    #1;
    bus.ps2_data_en = 1'b0;
    check("exp_no_drop", int'(bus.packet_drop), 0);
    check("exp_state", int'(bus.dbg_state), int'(S_B2));
    send_byte(8'h00);
    tick();
    check("exp_commit_x", int'(bus.mouse_x), 7);

    // reset mid-packet
    send_byte(8'h08);
    send_byte(8'h01);
    v0 = valid_seen;
    do_reset();
    check("midrst_x", int'(bus.mouse_x), 320);
    check("midrst_y", int'(bus.mouse_y), 240);
    check("midrst_novalid", valid_seen, v0);
    check("midrst_btn", int'({bus.middle_button, bus.right_button, bus.left_button}), 0);
    send_pkt(8'h08, 8'h01, 8'h00, 321, 240);
    // y overflow saturates to +255 then clamps at 0
    send_pkt(8'h88, 8'h00, 8'h00, 321, 0);
    send_pkt(8'h09, 8'h00, 8'h00, 321, 0);
    send_pkt(8'h09, 8'h00, 8'h00, 321, 0);

    repeat (4) tick();
    check("exp_q_empty", exp_q.size(), 0);
    check("drop_q_empty", drop_q.size(), 0);
    check("valid_total", valid_seen, 15);
    check("drop_total", drop_seen, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
